// File: rtl/sonar_ping_scheduler.sv
`timescale 1ns/1ps
// Round-robin sonar ping/listen sequencer: clear, burst, blank and listen on each enabled
// channel in ascending order, reporting time-of-flight per channel and a done pulse per sweep.
module sonar_ping_scheduler #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TX_HALF = 1250,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [N_CH-1:0]  en_mask_i,
    input  logic [7:0]       burst_len_i,
    input  logic [CNT_W-1:0] blank_i,
    input  logic [CNT_W-1:0] window_i,
    input  logic             ce_pcm,
    input  logic [N_CH-1:0]  cmp,
    output logic             mclear_o,
    output logic             tx_o,
    output logic [CH_W-1:0]  ch_o,
    output logic             busy_o,
    output logic             res_valid_o,
    output logic [CH_W-1:0]  res_ch_o,
    output logic [CNT_W-1:0] res_tof_o,
    output logic             res_to_o,
    output logic             done_irq_o
);
    localparam int unsigned     HC_W    = (TX_HALF > 1) ? $clog2(TX_HALF) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(TX_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BURST,
        BLANK,
        LISTEN,
        STORE
    } state_t;

    state_t           state;
    logic [N_CH-1:0]  mask_r;
    logic [7:0]       burst_r;
    logic [CNT_W-1:0] blank_r;
    logic [CNT_W-1:0] window_r;
    logic [HC_W-1:0]  hc;
    logic [7:0]       halves;
    logic [CNT_W-1:0] tof;
    logic [CNT_W-1:0] win;

    logic [CH_W:0]    lowest;
    logic [CH_W:0]    nxt;
    logic             win_hit;

    // {found, index} of the lowest set bit of m at or above position lo
    function automatic logic [CH_W:0] pick_from(input logic [N_CH-1:0] m, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    assign lowest  = pick_from(en_mask_i, 0);
    assign nxt     = pick_from(mask_r, int'(ch_o) + 1);
    // window expires on the tick that brings the tick count up to window (window=0: first tick)
    assign win_hit = ((CNT_W+1)'(win) + (CNT_W+1)'(1)) >= (CNT_W+1)'(window_r);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            mask_r      <= '0;
            burst_r     <= '0;
            blank_r     <= '0;
            window_r    <= '0;
            hc          <= '0;
            halves      <= '0;
            tof         <= '0;
            win         <= '0;
            mclear_o    <= 1'b0;
            tx_o        <= 1'b0;
            ch_o        <= '0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
            res_ch_o    <= '0;
            res_tof_o   <= '0;
            res_to_o    <= 1'b0;
            done_irq_o  <= 1'b0;
        end else if (abort_i) begin
            state       <= IDLE;
            hc          <= '0;
            halves      <= '0;
            tof         <= '0;
            win         <= '0;
            mclear_o    <= 1'b0;
            tx_o        <= 1'b0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
            done_irq_o  <= 1'b0;
        end else begin
            mclear_o    <= 1'b0;
            res_valid_o <= 1'b0;
            done_irq_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && (|en_mask_i)) begin
                        mask_r   <= en_mask_i;
                        burst_r  <= burst_len_i;
                        blank_r  <= blank_i;
                        window_r <= window_i;
                        ch_o     <= lowest[CH_W-1:0];
                        busy_o   <= 1'b1;
                        mclear_o <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    hc     <= '0;
                    halves <= '0;
                    tof    <= '0;
                    if (burst_r == 8'd0) begin
                        state <= BLANK;
                    end else begin
                        tx_o  <= 1'b1;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (hc == HC_LAST) begin
                        hc <= '0;
                        if (halves == burst_r - 8'd1) begin
                            tx_o  <= 1'b0;
                            state <= BLANK;
                        end else begin
                            halves <= halves + 8'd1;
                            tx_o   <= ~tx_o;
                        end
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end
                BLANK: begin
                    if (tof == blank_r) begin
                        win   <= '0;
                        state <= LISTEN;
                    end else if (ce_pcm) begin
                        tof <= tof + CNT_W'(1);
                    end
                end
                LISTEN: begin
                    // an echo beats both the tick and the timeout in the same cycle
                    if (cmp[ch_o]) begin
                        res_tof_o   <= tof;
                        res_to_o    <= 1'b0;
                        res_ch_o    <= ch_o;
                        res_valid_o <= 1'b1;
                        state       <= STORE;
                    end else if (ce_pcm) begin
                        if (win_hit) begin
                            res_tof_o   <= '1;
                            res_to_o    <= 1'b1;
                            res_ch_o    <= ch_o;
                            res_valid_o <= 1'b1;
                            state       <= STORE;
                        end else begin
                            win <= win + CNT_W'(1);
                            if (tof != '1) tof <= tof + CNT_W'(1);
                        end
                    end
                end
                STORE: begin
                    if (nxt[CH_W]) begin
                        ch_o     <= nxt[CH_W-1:0];
                        mclear_o <= 1'b1;
                        state    <= CLEAR;
                    end else begin
                        busy_o     <= 1'b0;
                        done_irq_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_ping_scheduler.sv
`timescale 1ns/1ps
// Bench for sonar_ping_scheduler: a sweep-level model walks each channel's phases, drives
// randomized ce_pcm/cmp/config noise and checks every DUT output every cycle.
module tb_sonar_ping_scheduler;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TX_HALF = 4;
    localparam logic [CNT_W-1:0] ALL1 = '1;
    localparam int TOF_MAX = (2 ** CNT_W) - 1;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [N_CH-1:0]  en_mask_i = '0;
    logic [7:0]       burst_len_i = '0;
    logic [CNT_W-1:0] blank_i = '0;
    logic [CNT_W-1:0] window_i = '0;
    logic             ce_pcm = 1'b0;
    logic [N_CH-1:0]  cmp = '0;
    logic             mclear_o, tx_o, busy_o, res_valid_o, res_to_o, done_irq_o;
    logic [0:0]       ch_o, res_ch_o;
    logic [CNT_W-1:0] res_tof_o;

    sonar_ping_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W), .TX_HALF(TX_HALF)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
        .en_mask_i(en_mask_i), .burst_len_i(burst_len_i), .blank_i(blank_i),
        .window_i(window_i), .ce_pcm(ce_pcm), .cmp(cmp), .mclear_o(mclear_o), .tx_o(tx_o),
        .ch_o(ch_o), .busy_o(busy_o), .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
        .res_tof_o(res_tof_o), .res_to_o(res_to_o), .done_irq_o(done_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad = 0;

    // expected outputs for the current cycle
    bit               chk_en = 1'b0;
    logic             exp_busy = 1'b0, exp_mclear = 1'b0, exp_tx = 1'b0;
    logic             exp_valid = 1'b0, exp_done = 1'b0, exp_rto = 1'b0;
    logic [0:0]       exp_ch = '0, exp_rch = '0;
    logic [CNT_W-1:0] exp_rtof = '0;

    // stimulus knobs
    int echo_tgt [N_CH];
    bit junk = 1'b0;
    bit blank_cmp = 1'b0;
    bit ce_on_echo = 1'b0;

    // observation log used by the literal checks
    int               log_ch [$];
    logic [CNT_W-1:0] log_tof [$];
    int               log_to [$];
    int               n_tx_hi = 0, n_mclear = 0, n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // compare this cycle's outputs, log them, then advance to just after the next edge
    task automatic cyc();
        @(negedge wb_clk_i);
        if (chk_en) begin
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("mclear", 32'(mclear_o), 32'(exp_mclear));
            check("tx", 32'(tx_o), 32'(exp_tx));
            check("res_valid", 32'(res_valid_o), 32'(exp_valid));
            check("done_irq", 32'(done_irq_o), 32'(exp_done));
            check("res_ch", 32'(res_ch_o), 32'(exp_rch));
            check("res_tof", 32'(res_tof_o), 32'(exp_rtof));
            check("res_to", 32'(res_to_o), 32'(exp_rto));
            if (exp_busy) check("ch", 32'(ch_o), 32'(exp_ch));
        end
        if (res_valid_o) begin
            log_ch.push_back(int'(res_ch_o));
            log_tof.push_back(res_tof_o);
            log_to.push_back(int'(res_to_o));
        end
        if (tx_o) n_tx_hi++;
        if (mclear_o) n_mclear++;
        if (done_irq_o) n_done++;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive_quiet();
        start_i = 1'b0;
        abort_i = 1'b0;
        cmp = '0;
        ce_pcm = 1'($urandom);
    endtask

    // inputs during a sweep: noise the DUT must ignore when junk is set
    task automatic drive_busy();
        start_i = junk ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        abort_i = 1'b0;
        if (junk) begin
            en_mask_i = N_CH'($urandom);
            burst_len_i = 8'($urandom);
            blank_i = CNT_W'($urandom);
            window_i = CNT_W'($urandom);
        end
        cmp = junk ? N_CH'($urandom) : '0;
        ce_pcm = 1'($urandom);
    endtask

    // one sweep from an idle cycle; abort_at >= 0 aborts (or resets) in that LISTEN cycle of the first channel
    task automatic sweep(input logic [N_CH-1:0] mask, input int burst, input int blank,
                         input int window, input int abort_at, input bit use_rst);
        int tof, win, guard;
        logic [CNT_W-1:0] r_tof;
        logic r_to;
        bit fin, first;
        en_mask_i = mask;
        burst_len_i = 8'(burst);
        blank_i = CNT_W'(blank);
        window_i = CNT_W'(window);
        start_i = 1'b1;
        abort_i = 1'b0;
        cmp = '0;
        ce_pcm = 1'($urandom);
        r_tof = '0;
        r_to = 1'b0;
        if (mask == '0) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                drive_quiet();
            end
            return;
        end
        first = 1'b1;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (!mask[c]) continue;
            cyc();
            drive_busy();
            exp_mclear = 1'b1; exp_busy = 1'b1; exp_ch = 1'(c);
            exp_tx = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
            for (int i = 0; i < burst * int'(TX_HALF); i++) begin
                cyc();
                drive_busy();
                exp_mclear = 1'b0;
                exp_tx = ((i / int'(TX_HALF)) % 2) == 0;
            end
            tof = 0;
            guard = 0;
            forever begin
                cyc();
                drive_busy();
                exp_mclear = 1'b0;
                exp_tx = 1'b0;
                if (blank_cmp) cmp[c] = 1'b1;
                if (tof == blank) break;
                if (ce_pcm) tof++;
                guard++;
                if (guard > 5000) begin
                    check("blank_bound", 32'(guard), 32'(0));
                    break;
                end
            end
            win = 0;
            fin = 1'b0;
            guard = 0;
            while (!fin) begin
                cyc();
                drive_busy();
                exp_mclear = 1'b0;
                exp_tx = 1'b0;
                cmp[c] = 1'b0;
                if (first && abort_at >= 0 && guard == abort_at) begin
                    cmp = '0;
                    if (use_rst) wb_rst_i = 1'b1;
                    else begin
                        abort_i = 1'b1;
                        start_i = 1'($urandom);
                    end
                    cyc();
                    wb_rst_i = 1'b0;
                    drive_quiet();
                    exp_busy = 1'b0; exp_mclear = 1'b0; exp_tx = 1'b0;
                    exp_valid = 1'b0; exp_done = 1'b0;
                    if (use_rst) begin
                        exp_rch = '0; exp_rtof = '0; exp_rto = 1'b0;
                    end
                    return;
                end
                if (echo_tgt[c] >= 0 && tof == echo_tgt[c]) begin
                    cmp[c] = 1'b1;
                    if (ce_on_echo) ce_pcm = 1'b1;
                    r_tof = CNT_W'(tof);
                    r_to = 1'b0;
                    fin = 1'b1;
                end else if (ce_pcm) begin
                    if (win + 1 >= window) begin
                        r_tof = ALL1;
                        r_to = 1'b1;
                        fin = 1'b1;
                    end else begin
                        win++;
                        if (tof < TOF_MAX) tof++;
                    end
                end
                guard++;
                if (guard > 5000) begin
                    check("listen_bound", 32'(guard), 32'(0));
                    fin = 1'b1;
                end
            end
            cyc();
            drive_busy();
            exp_valid = 1'b1; exp_rch = 1'(c); exp_rtof = r_tof; exp_rto = r_to;
            first = 1'b0;
        end
        cyc();
        drive_quiet();
        exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
        cyc();
        drive_quiet();
        exp_done = 1'b0;
    endtask

    initial begin
        int b, d, m;
        int bl, wn, ab;
        bit ur;
        for (int k = 0; k < int'(N_CH); k++) echo_tgt[k] = -1;

        // reset and mask-0 start
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_tx", 32'(tx_o), 32'(0));
        check("rst_mclear", 32'(mclear_o), 32'(0));
        check("rst_ch", 32'(ch_o), 32'(0));
        check("rst_res", 32'({res_valid_o, res_ch_o, res_to_o, done_irq_o}), 32'(0));
        check("rst_tof", 32'(res_tof_o), 32'(0));
        sweep(2'b00, 1, 1, 1, -1, 1'b0);
        check("mask0_busy", 32'(busy_o), 32'(0));

        // two channels with echoes at 10 and 15
        echo_tgt[0] = 10; echo_tgt[1] = 15;
        b = log_ch.size(); d = n_done;
        sweep(2'b11, 4, 3, 20, -1, 1'b0);
        check("t2_count", 32'(log_ch.size() - b), 32'(2));
        check("t2_r0_ch", 32'(log_ch[b]), 32'(0));
        check("t2_r0_tof", 32'(log_tof[b]), 32'd10);
        check("t2_r0_to", 32'(log_to[b]), 32'(0));
        check("t2_r1_ch", 32'(log_ch[b+1]), 32'(1));
        check("t2_r1_tof", 32'(log_tof[b+1]), 32'd15);
        check("t2_r1_to", 32'(log_to[b+1]), 32'(0));
        check("t2_done", 32'(n_done - d), 32'(1));

        // ch1 only, no echo
        echo_tgt[0] = -1; echo_tgt[1] = -1;
        b = log_ch.size(); m = n_mclear;
        sweep(2'b10, 2, 2, 5, -1, 1'b0);
        check("t3_ch", 32'(log_ch[b]), 32'(1));
        check("t3_tof", 32'(log_tof[b]), 32'h0000_FFFF);
        check("t3_to", 32'(log_to[b]), 32'(1));
        check("t3_mclear", 32'(n_mclear - m), 32'(1));

        // cmp only during blanking -> timeout; echo coincident with a tick
        blank_cmp = 1'b1;
        b = log_ch.size();
        sweep(2'b01, 1, 4, 3, -1, 1'b0);
        check("t4_blank_to", 32'(log_to[b]), 32'(1));
        blank_cmp = 1'b0;
        ce_on_echo = 1'b1;
        echo_tgt[0] = 6;
        b = log_ch.size();
        sweep(2'b01, 0, 2, 20, -1, 1'b0);
        check("t4_coinc_tof", 32'(log_tof[b]), 32'd6);
        check("t4_coinc_to", 32'(log_to[b]), 32'(0));
        ce_on_echo = 1'b0;

        // burst shape: 4 half-periods of 4 cycles, and burst=0
        m = n_tx_hi;
        sweep(2'b01, 4, 1, 2, -1, 1'b0);
        check("t5_tx_hi", 32'(n_tx_hi - m), 32'd8);
        m = n_tx_hi;
        sweep(2'b01, 0, 1, 2, -1, 1'b0);
        check("t5_burst0", 32'(n_tx_hi - m), 32'd0);

        // abort in LISTEN of ch0, then a full sweep
        echo_tgt[0] = -1; echo_tgt[1] = -1;
        b = log_ch.size(); d = n_done;
        sweep(2'b11, 1, 1, 30, 2, 1'b0);
        check("t6_abort_res", 32'(log_ch.size() - b), 32'(0));
        check("t6_abort_done", 32'(n_done - d), 32'(0));
        echo_tgt[0] = 5; echo_tgt[1] = 7;
        b = log_ch.size(); d = n_done;
        sweep(2'b11, 1, 2, 20, -1, 1'b0);
        check("t6_after_res", 32'(log_ch.size() - b), 32'(2));
        check("t6_after_done", 32'(n_done - d), 32'(1));

        // abort and start together in IDLE: nothing starts
        en_mask_i = 2'b11;
        start_i = 1'b1;
        abort_i = 1'b1;
        cyc();
        drive_quiet();
        cyc();
        check("abort_start_busy", 32'(busy_o), 32'(0));

        // reset mid-sweep clears result fields
        sweep(2'b11, 1, 1, 30, 1, 1'b1);

        // randomized sweeps with input noise
        junk = 1'b1;
        for (int it = 0; it < 40; it++) begin
            m = int'($urandom_range(0, 3));
            b = int'($urandom_range(0, 3));
            bl = int'($urandom_range(0, 6));
            wn = int'($urandom_range(0, 10));
            for (int k = 0; k < int'(N_CH); k++)
                echo_tgt[k] = ($urandom_range(0, 2) == 0) ? -1 : bl + int'($urandom_range(0, 12));
            ce_on_echo = 1'($urandom);
            blank_cmp = 1'($urandom);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            ur = 1'($urandom);
            sweep(N_CH'(m), b, bl, wn, ab, ur);
            cyc();
            drive_quiet();
        end
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
